// File: rtl/pe_pkg.sv
// Shared definitions for the polynomial-engine arithmetic blocks.
// Holds the coefficient width, the two supported moduli, the modulus-select
// encoding and the operand bundle passed to the modular multiplier.
package pe_pkg;

    localparam int COEF_W = 23;

    localparam logic [COEF_W-1:0] Q_KYBER     = 23'd3329;
    localparam logic [COEF_W-1:0] Q_DILITHIUM = 23'd8380417;

    typedef enum logic {
        SEL_KYBER     = 1'b0,
        SEL_DILITHIUM = 1'b1
    } mod_sel_e;

    typedef struct packed {
        logic [COEF_W-1:0] a;
        logic [COEF_W-1:0] b;
        mod_sel_e          sel;
    } mul_req_t;

endpackage

// File: rtl/mod_mul.sv
// Combinational modular multiplier: c = (a * b) mod q, where q is chosen by sel
// (Kyber 3329 or Dilithium 8380417). The full 46-bit product is formed before
// reduction so Dilithium operands up to q-1 are handled exactly.
// Ports:
//   a, b : operands, expected to be below the selected modulus
//   sel  : modulus select
//   c    : reduced product; upper bits are zero for the Kyber modulus
module mod_mul
    import pe_pkg::*;
(
    input  logic [COEF_W-1:0] a,
    input  logic [COEF_W-1:0] b,
    input  mod_sel_e          sel,
    output logic [COEF_W-1:0] c
);

    localparam int PROD_W = 2 * COEF_W;
    localparam logic [PROD_W-1:0] Q_KYBER_W     = PROD_W'(Q_KYBER);
    localparam logic [PROD_W-1:0] Q_DILITHIUM_W = PROD_W'(Q_DILITHIUM);

    logic [PROD_W-1:0] prod;

    assign prod = {{COEF_W{1'b0}}, a} * {{COEF_W{1'b0}}, b};

    // Remainders are always below the modulus, so truncating to COEF_W is lossless.
    assign c = (sel == SEL_KYBER) ? COEF_W'(prod % Q_KYBER_W)
                                  : COEF_W'(prod % Q_DILITHIUM_W);

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter. The search starts one past the most recent winner and
// wraps, so after a grant the winner drops to lowest priority. The pointer only
// moves when the grant is actually taken (advance high with a grant present).
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   req         : request vector
//   advance     : downstream can take the granted request this cycle
//   grant       : one-hot grant (zero when no request)
//   grant_idx   : index of the granted requester
//   grant_valid : at least one request present
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_valid
);

    logic [ID_W-1:0] last_reg;
    logic [ID_W-1:0] cand_idx;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand_idx    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand_idx = ID_W'((int'(last_reg) + i) % NUM_REQ);
            if (!grant_valid && req[cand_idx]) begin
                grant_valid     = 1'b1;
                grant_idx       = cand_idx;
                grant[cand_idx] = 1'b1;
            end
        end
    end

    // Reset to the last index so requester 0 is searched first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_reg <= ID_W'(NUM_REQ - 1);
        end else if (advance && grant_valid) begin
            last_reg <= grant_idx;
        end
    end

endmodule

// File: rtl/mod_mul_arbiter.sv
// Shares one modular multiplier between NUM_REQ requesters.
// Two-stage stallable pipeline: S1 registers the round-robin winner's operands,
// the multiplier reduces them combinationally, S2 registers the tagged result.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   req_valid_i  : per-requester operation valid
//   req_ready_o  : per-requester accept, one-hot or zero
//   req_a_i/b_i  : packed operands, requester i at [i*23 +: 23]
//   req_sel_i    : per-requester modulus select (0 Kyber, 1 Dilithium)
//   rsp_valid_o / rsp_ready_i : result handshake
//   rsp_id_o     : issuing requester index
//   rsp_c_o      : (a*b) mod q
//   busy_o       : an operation is held in S1 or S2
//   op_cnt_o     : completed responses, wrapping
module mod_mul_arbiter
    import pe_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic [NUM_REQ*COEF_W-1:0] req_a_i,
    input  logic [NUM_REQ*COEF_W-1:0] req_b_i,
    input  logic [NUM_REQ-1:0]        req_sel_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [ID_W-1:0]           rsp_id_o,
    output logic [COEF_W-1:0]         rsp_c_o,
    output logic                      busy_o,
    output logic [31:0]               op_cnt_o
);

    mul_req_t        req_ops [NUM_REQ];
    mul_req_t        s1_req_reg;
    logic [ID_W-1:0] s1_id_reg;
    logic            v1_reg;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_valid;
    logic               adv1;
    logic               adv2;
    logic [COEF_W-1:0]  mul_c;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_ops[gi] = '{
                a:   req_a_i[gi*COEF_W +: COEF_W],
                b:   req_b_i[gi*COEF_W +: COEF_W],
                sel: mod_sel_e'(req_sel_i[gi])
            };
        end
    endgenerate

    // A stage may load when it is empty or its contents move on this edge,
    // which lets a full pipeline drain and refill in the same cycle.
    assign adv2 = !rsp_valid_o || rsp_ready_i;
    assign adv1 = !v1_reg || adv2;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk         (clk_i),
        .rst         (rst_i),
        .req         (req_valid_i),
        .advance     (adv1),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign req_ready_o = grant & {NUM_REQ{adv1}};

    mod_mul u_mul (
        .a   (s1_req_reg.a),
        .b   (s1_req_reg.b),
        .sel (s1_req_reg.sel),
        .c   (mul_c)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v1_reg      <= 1'b0;
            s1_req_reg  <= '0;
            s1_id_reg   <= '0;
            rsp_valid_o <= 1'b0;
            rsp_id_o    <= '0;
            rsp_c_o     <= '0;
            op_cnt_o    <= '0;
        end else begin
            if (adv1) begin
                v1_reg <= grant_valid;
                if (grant_valid) begin
                    s1_req_reg <= req_ops[grant_idx];
                    s1_id_reg  <= grant_idx;
                end
            end
            // Result fields only change when a real operation moves in, so the
            // last result stays visible after a drain instead of stale S1 data.
            if (adv2) begin
                rsp_valid_o <= v1_reg;
                if (v1_reg) begin
                    rsp_c_o  <= mul_c;
                    rsp_id_o <= s1_id_reg;
                end
            end
            if (rsp_valid_o && rsp_ready_i) begin
                op_cnt_o <= op_cnt_o + 32'd1;
            end
        end
    end

    assign busy_o = v1_reg || rsp_valid_o;

endmodule

// File: tb/tb_mod_mul_arbiter.sv
// Self-checking bench for mod_mul_arbiter with two requesters.
// Inputs change on the falling edge; outputs are read on the falling edge.
module tb_mod_mul_arbiter;

    localparam int N  = 2;
    localparam int IW = 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*23-1:0] req_a;
    logic [N*23-1:0] req_b;
    logic [N-1:0]    req_sel;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [IW-1:0]   rsp_id;
    logic [22:0]     rsp_c;
    logic            busy;
    logic [31:0]     op_cnt;

    always #5 clk = ~clk;

    mod_mul_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .req_sel_i   (req_sel),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_id_o    (rsp_id),
        .rsp_c_o     (rsp_c),
        .busy_o      (busy),
        .op_cnt_o    (op_cnt)
    );

    // Operand contract: values must be below the selected modulus.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i]) begin
                    assert (req_sel[i] ? (req_a[i*23 +: 23] < 23'd8380417 && req_b[i*23 +: 23] < 23'd8380417)
                                       : (req_a[i*23 +: 23] < 23'd3329 && req_b[i*23 +: 23] < 23'd3329))
                    else $error("operand contract violated on requester %0d", i);
                end
            end
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [IW-1:0] id;
        logic [22:0]   c;
    } exp_t;

    exp_t       exp_q[$];
    int         inflight = 0;
    int         rsp_cnt  = 0;
    logic [N-1:0] hs_mask;
    bit         chk_busy = 1'b0;

    function automatic logic [22:0] gold(input logic [22:0] a, input logic [22:0] b, input logic sel);
        logic [63:0] p;
        p = {41'd0, a} * {41'd0, b};
        return 23'(p % (sel ? 64'd8380417 : 64'd3329));
    endfunction

    task automatic drive_op(input int r, input logic [22:0] a, input logic [22:0] b, input logic sel);
        req_valid[r]       = 1'b1;
        req_a[r*23 +: 23]  = a;
        req_b[r*23 +: 23]  = b;
        req_sel[r]         = sel;
    endtask

    // Settle, record request/response handshakes against the scoreboard,
    // then advance to the next falling edge.
    task automatic step();
        exp_t e;
        #1;
        if (chk_busy) check("busy", 64'(busy), 64'(inflight != 0));
        hs_mask = '0;
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                hs_mask[i] = 1'b1;
                e.id = IW'(i);
                e.c  = gold(req_a[i*23 +: 23], req_b[i*23 +: 23], req_sel[i]);
                exp_q.push_back(e);
                inflight++;
                $display("t=%0t req  id=%0d a=%0d b=%0d sel=%0d", $time, i,
                         req_a[i*23 +: 23], req_b[i*23 +: 23], req_sel[i]);
            end
        end
        if (rsp_valid && rsp_ready) begin
            rsp_cnt++;
            inflight--;
            $display("t=%0t rsp  id=%0d c=%0d", $time, rsp_id, rsp_c);
            check("rsp_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rsp_id", 64'(rsp_id), 64'(e.id));
                check("rsp_c", 64'(rsp_c), 64'(e.c));
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int base;
        int gaps;
        int issued;
        int r;
        bit pending;
        logic [22:0] ta [16];
        logic [22:0] tb [16];
        logic        ts [16];

        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_sel   = '0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_valid", 64'(rsp_valid), 64'd0);
        check("rst_c", 64'(rsp_c), 64'd0);
        check("rst_id", 64'(rsp_id), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_cnt", 64'(op_cnt), 64'd0);
        rst      = 1'b0;
        chk_busy = 1'b1;
        @(negedge clk);

        // Single Kyber op: 3000*2000 mod 3329 = 1142
        drive_op(0, 23'd3000, 23'd2000, 1'b0);
        #1;
        check("t1_ready", 64'(req_ready), 64'd1);
        step();
        req_valid = '0;
        check("t1_lat1", 64'(rsp_valid), 64'd0);
        step();
        check("t1_valid", 64'(rsp_valid), 64'd1);
        check("t1_c", 64'(rsp_c), 64'd1142);
        check("t1_id", 64'(rsp_id), 64'd0);
        step();
        check("t1_cnt", 64'(op_cnt), 64'd1);

        // Single Dilithium op: (q-1)^2 mod q = 1
        drive_op(1, 23'd8380416, 23'd8380416, 1'b1);
        step();
        req_valid = '0;
        step();
        check("t2_valid", 64'(rsp_valid), 64'd1);
        check("t2_c", 64'(rsp_c), 64'd1);
        check("t2_id", 64'(rsp_id), 64'd1);
        step();
        check("t2_cnt", 64'(op_cnt), 64'd2);

        // Fairness: both requesters valid for 8 cycles
        for (int k = 0; k < 10; k++) begin
            if (k < 8) begin
                drive_op(0, 23'd2, 23'd3, 1'b0);
                drive_op(1, 23'd5, 23'd7, 1'b0);
            end else begin
                req_valid = '0;
            end
            #1;
            if (k < 8) check("fair_grant", 64'(req_ready), (k % 2 == 0) ? 64'd1 : 64'd2);
            if (k >= 2) begin
                check("fair_valid", 64'(rsp_valid), 64'd1);
                check("fair_c", 64'(rsp_c), (k % 2 == 0) ? 64'd6 : 64'd35);
                check("fair_id", 64'(rsp_id), 64'(k % 2));
            end
            step();
        end
        check("fair_cnt", 64'(op_cnt), 64'd10);
        check("fair_idle", 64'(rsp_valid), 64'd0);

        // Backpressure: 4 ops from requester 0, consumer stalled
        rsp_ready = 1'b0;
        p = 0;
        base = rsp_cnt;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (p < 4) drive_op(0, 23'(10 * (p + 1)), 23'd11, 1'b0);
            #1;
            if (cyc >= 2) check("bp_ready", 64'(req_ready), 64'd0);
            step();
            if (hs_mask[0]) p++;
            if (cyc >= 1) begin
                check("bp_hold_valid", 64'(rsp_valid), 64'd1);
                check("bp_hold_c", 64'(rsp_c), 64'd110);
                check("bp_hold_id", 64'(rsp_id), 64'd0);
            end
        end
        check("bp_accepted", 64'(p), 64'd2);
        rsp_ready = 1'b1;
        for (int t = 0; t < 30 && rsp_cnt - base < 4; t++) begin
            if (p < 4) drive_op(0, 23'(10 * (p + 1)), 23'd11, 1'b0);
            else req_valid[0] = 1'b0;
            step();
            if (hs_mask[0]) p++;
        end
        req_valid = '0;
        check("bp_done", 64'(rsp_cnt - base), 64'd4);
        check("bp_cnt", 64'(op_cnt), 64'd14);
        check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

        // Full throughput: 16 random legal ops back to back
        for (int j = 0; j < 16; j++) begin
            ts[j] = 1'($urandom_range(0, 1));
            ta[j] = ts[j] ? 23'($urandom_range(0, 8380416)) : 23'($urandom_range(0, 3328));
            tb[j] = ts[j] ? 23'($urandom_range(0, 8380416)) : 23'($urandom_range(0, 3328));
        end
        base = rsp_cnt;
        gaps = 0;
        for (int cyc = 0; cyc < 18; cyc++) begin
            if (cyc < 16) drive_op(0, ta[cyc], tb[cyc], ts[cyc]);
            else req_valid[0] = 1'b0;
            #1;
            if (cyc < 16) check("tp_ready", 64'(req_ready), 64'd1);
            if (cyc >= 2 && !rsp_valid) gaps++;
            step();
        end
        check("tp_gaps", 64'(gaps), 64'd0);
        check("tp_done", 64'(rsp_cnt - base), 64'd16);
        check("tp_cnt", 64'(op_cnt), 64'd30);

        // Reset while S1 and S2 both hold operations
        rsp_ready = 1'b0;
        drive_op(0, 23'd100, 23'd200, 1'b0);
        step();
        drive_op(0, 23'd300, 23'd400, 1'b0);
        step();
        req_valid = '0;
        check("mr_pre_busy", 64'(busy), 64'd1);
        check("mr_pre_valid", 64'(rsp_valid), 64'd1);
        rst = 1'b1;
        chk_busy = 1'b0;
        #1;
        check("mr_valid", 64'(rsp_valid), 64'd0);
        check("mr_c", 64'(rsp_c), 64'd0);
        check("mr_id", 64'(rsp_id), 64'd0);
        check("mr_busy", 64'(busy), 64'd0);
        check("mr_cnt", 64'(op_cnt), 64'd0);
        exp_q.delete();
        inflight = 0;
        @(negedge clk);
        rst = 1'b0;
        rsp_ready = 1'b1;
        chk_busy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("mr_no_rsp", 64'(rsp_valid), 64'd0);
            step();
        end
        drive_op(0, 23'd7, 23'd8, 1'b0);
        drive_op(1, 23'd9, 23'd9, 1'b0);
        #1;
        check("mr_grant0", 64'(req_ready), 64'd1);
        step();
        req_valid = '0;
        step();
        check("mr_c_after", 64'(rsp_c), 64'd56);
        step();
        check("mr_cnt_after", 64'(op_cnt), 64'd1);

        // Sparse traffic with random consumer stalls
        base = rsp_cnt;
        issued = 0;
        pending = 1'b0;
        r = 0;
        for (int cyc = 0; cyc < 400 && rsp_cnt - base < 20; cyc++) begin
            if (!pending && issued < 20 && cyc % 5 == 0) begin
                r = issued % 2;
                if (issued % 3 == 0)
                    drive_op(r, 23'($urandom_range(0, 8380416)), 23'($urandom_range(0, 8380416)), 1'b1);
                else
                    drive_op(r, 23'($urandom_range(0, 3328)), 23'($urandom_range(0, 3328)), 1'b0);
                pending = 1'b1;
            end
            rsp_ready = 1'($urandom_range(0, 1));
            step();
            if (pending && hs_mask[r]) begin
                pending = 1'b0;
                issued++;
                req_valid[r] = 1'b0;
            end
        end
        check("sp_done", 64'(rsp_cnt - base), 64'd20);
        rsp_ready = 1'b1;
        req_valid = '0;
        step();
        step();
        check("sp_idle", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
